// File: rtl/dmem_responder.sv
// Single-port data-memory responder for a pipeline MEM stage: accepts one
// request at a time, commits stores / samples loads after a fixed latency,
// and holds the response until the pipeline takes it.
module dmem_responder #(
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [1:0]  i_acc_type,
    input  logic [1:0]  i_access_sz,
    input  logic        i_s_us,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int unsigned BYTE_AW = $clog2(DEPTH_WORDS * 4);
    localparam int unsigned WORD_AW = BYTE_AW - 2;
    localparam int unsigned CNT_W   = 2;

    localparam logic [1:0] ACC_RD = 2'b01;
    localparam logic [1:0] ACC_WR = 2'b10;
    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;

    logic [1:0]         r_acc;
    logic [1:0]         r_sz;
    logic               r_sus;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;

    logic [31:0]        r_mem [DEPTH_WORDS];

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_req_ready_nxt;
    logic               w_rsp_valid_nxt;
    logic [31:0]        w_rsp_rdata_nxt;
    logic               w_rsp_err_nxt;
    logic               w_capture;
    logic               w_commit;

    logic               w_err;
    logic [WORD_AW-1:0] w_word_idx;
    logic [31:0]        w_rd_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load;
    logic [3:0]         w_be;
    logic [31:0]        w_wr_word;

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

    assign w_word_idx = r_addr[BYTE_AW-1:2];
    assign w_rd_word  = r_mem[w_word_idx];

    // Classify the captured request: illegal encodings, misalignment, range.
    always_comb begin
        w_err = 1'b0;
        if ((r_acc != ACC_RD) && (r_acc != ACC_WR)) w_err = 1'b1;
        if (r_sz == 2'b11)                          w_err = 1'b1;
        if ((r_sz == SZ_H) && r_addr[0])            w_err = 1'b1;
        if ((r_sz == SZ_W) && (r_addr[1:0] != 2'b00)) w_err = 1'b1;
        if (r_addr[31:BYTE_AW] != '0)               w_err = 1'b1;
    end

    // Load lane selection and extension.
    always_comb begin
        w_byte = w_rd_word[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
        case (r_sz)
            SZ_B:    w_load = {{24{w_byte[7] & ~r_sus}}, w_byte};
            SZ_H:    w_load = {{16{w_half[15] & ~r_sus}}, w_half};
            default: w_load = w_rd_word;
        endcase
    end

    // Store byte enables; data is replicated so every enabled lane sees it.
    always_comb begin
        w_be      = 4'b0000;
        w_wr_word = 32'h0;
        case (r_sz)
            SZ_B: begin
                w_be      = 4'b0001 << r_addr[1:0];
                w_wr_word = {4{r_wdata[7:0]}};
            end
            SZ_H: begin
                w_be      = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wr_word = {2{r_wdata[15:0]}};
            end
            SZ_W: begin
                w_be      = 4'b1111;
                w_wr_word = r_wdata;
            end
            default: begin
                w_be      = 4'b0000;
                w_wr_word = 32'h0;
            end
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_req_ready_nxt = r_req_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_capture       = 1'b0;
        w_commit        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready_nxt = 1'b1;
                if (i_req_valid && r_req_ready) begin
                    w_capture       = 1'b1;
                    w_state_nxt     = S_WAIT;
                    w_cnt_nxt       = CNT_W'(LATENCY - 1);
                    w_req_ready_nxt = 1'b0;
                end
            end
            S_WAIT: begin
                w_req_ready_nxt = 1'b0;
                if (r_cnt == '0) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = w_err;
                    w_rsp_rdata_nxt = (!w_err && (r_acc == ACC_RD)) ? w_load : 32'h0;
                    w_commit        = !w_err && (r_acc == ACC_WR);
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                w_req_ready_nxt = 1'b0;
                if (i_rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_rdata_nxt = 32'h0;
                    w_rsp_err_nxt   = 1'b0;
                    w_req_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_req_ready_nxt = 1'b0;
                w_rsp_valid_nxt = 1'b0;
                w_rsp_rdata_nxt = 32'h0;
                w_rsp_err_nxt   = 1'b0;
            end
        endcase
    end

    // State, counter, registered outputs and request capture.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            if (w_capture) begin
                r_acc   <= i_acc_type;
                r_sz    <= i_access_sz;
                r_sus   <= i_s_us;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end
        end
    end

    // Storage array: never cleared, and a reset edge blocks a pending commit.
    always_ff @(posedge i_clk) begin
        if (i_reset && w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_word_idx][8*i +: 8] <= w_wr_word[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic compared against a byte-array memory model.
module tb_dmem_responder;

    typedef struct {
        logic [1:0]  acc;
        logic [1:0]  sz;
        logic        sus;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } op_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  rsp_ready;
    logic [1:0]  acc_type;
    logic [1:0]  access_sz;
    logic        s_us;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  req_ready;
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_err;
    logic [31:0] rdata0, rdata1, rdata2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] mm [0:1023];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.LATENCY(2), .DEPTH_WORDS(256)) u_dut_l2 (
        .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_acc_type(acc_type), .i_access_sz(access_sz), .i_s_us(s_us), .i_addr(addr),
        .i_wdata(wdata), .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
        .o_rsp_rdata(rdata0), .o_rsp_err(rsp_err[0]));

    dmem_responder #(.LATENCY(1), .DEPTH_WORDS(256)) u_dut_l1 (
        .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_acc_type(acc_type), .i_access_sz(access_sz), .i_s_us(s_us), .i_addr(addr),
        .i_wdata(wdata), .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
        .o_rsp_rdata(rdata1), .o_rsp_err(rsp_err[1]));

    dmem_responder #(.LATENCY(4), .DEPTH_WORDS(256)) u_dut_l4 (
        .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]),
        .i_acc_type(acc_type), .i_access_sz(access_sz), .i_s_us(s_us), .i_addr(addr),
        .i_wdata(wdata), .o_rsp_valid(rsp_valid[2]), .i_rsp_ready(rsp_ready[2]),
        .o_rsp_rdata(rdata2), .o_rsp_err(rsp_err[2]));

    function automatic logic [31:0] get_rdata(input int k);
        if (k == 0) return rdata0;
        if (k == 1) return rdata1;
        return rdata2;
    endfunction

    // Reference: little-endian byte memory, legality from the access rules.
    function automatic void model_access(input logic [1:0] acc, input logic [1:0] sz,
                                         input logic sus, input logic [31:0] a,
                                         input logic [31:0] wd, output logic [31:0] exp_rd,
                                         output logic exp_err);
        int nb;
        logic [31:0] v;
        nb      = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        exp_rd  = 32'h0;
        exp_err = !((acc == 2'b01) || (acc == 2'b10)) || (sz == 2'b11) ||
                  ((a % nb) != 0) || (a >= 32'd1024);
        if (!exp_err) begin
            if (acc == 2'b10) begin
                for (int i = 0; i < nb; i++) mm[int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mm[int'(a) + i];
                if (nb < 4 && !sus && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
                exp_rd = v;
            end
        end
    endfunction

    // Issue one request on instance k and collect its response.
    task automatic do_req(input int k, input logic [1:0] acc, input logic [1:0] sz,
                          input logic sus, input logic [31:0] a, input logic [31:0] wd,
                          input bit early, output logic [31:0] rd, output logic err,
                          output int lat, output int acc_cyc);
        int n;
        n = 0;
        while (!req_ready[k] && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (req_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_wait inst=%0d got=%b want=1", k, req_ready[k]);
        end
        acc_type = acc; access_sz = sz; s_us = sus; addr = a; wdata = wd;
        req_valid[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        req_valid[k] = 1'b0;
        if (early) rsp_ready[k] = 1'b1;
        acc_type = 2'($urandom); access_sz = 2'($urandom); s_us = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        lat = 0;
        while (!rsp_valid[k] && lat < 12) begin @(negedge clk); lat++; end
        checks++;
        if (rsp_valid[k] !== 1'b1) begin
            errors++;
            $display("FAIL rsp_valid_wait inst=%0d got=%b want=1", k, rsp_valid[k]);
        end
        rd  = get_rdata(k);
        err = rsp_err[k];
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({req_ready[k], rsp_valid[k], rsp_err[k], get_rdata(k)} !== 35'h0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d got rdy=%b vld=%b err=%b rd=%h want all 0",
                         k, req_ready[k], rsp_valid[k], rsp_err[k], get_rdata(k));
            end
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready got=%b want=111", req_ready);
        end
    endtask

    task automatic test_word_roundtrip();
        op_t t [2];
        logic [31:0] rd, mrd;
        logic err, merr;
        int lat, ac;
        t[0] = '{2'b10, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0};
        t[1] = '{2'b01, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        for (int i = 0; i < 2; i++) begin
            model_access(t[i].acc, t[i].sz, t[i].sus, t[i].a, t[i].wd, mrd, merr);
            do_req(0, t[i].acc, t[i].sz, t[i].sus, t[i].a, t[i].wd, 1'b0, rd, err, lat, ac);
            checks++;
            if (rd !== t[i].exp_rd || err !== t[i].exp_err || lat != 2) begin
                errors++;
                $display("FAIL roundtrip[%0d] got rd=%h err=%b lat=%0d want rd=%h err=%b lat=2",
                         i, rd, err, lat, t[i].exp_rd, t[i].exp_err);
            end
        end
    endtask

    task automatic test_extension();
        op_t t [7];
        logic [31:0] rd, mrd;
        logic err, merr;
        int lat, ac;
        t[0] = '{2'b01, 2'b00, 1'b0, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0};
        t[1] = '{2'b01, 2'b00, 1'b1, 32'h13, 32'h0,        32'h000000DE, 1'b0};
        t[2] = '{2'b01, 2'b01, 1'b0, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0};
        t[3] = '{2'b10, 2'b00, 1'b0, 32'h11, 32'hCCBBAA55, 32'h0,        1'b0};
        t[4] = '{2'b01, 2'b10, 1'b1, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0};
        t[5] = '{2'b01, 2'b01, 1'b1, 32'h12, 32'h0,        32'h0000DEAD, 1'b0};
        t[6] = '{2'b01, 2'b00, 1'b0, 32'h11, 32'h0,        32'h00000055, 1'b0};
        for (int i = 0; i < 7; i++) begin
            model_access(t[i].acc, t[i].sz, t[i].sus, t[i].a, t[i].wd, mrd, merr);
            do_req(0, t[i].acc, t[i].sz, t[i].sus, t[i].a, t[i].wd, 1'(i % 2), rd, err, lat, ac);
            checks++;
            if (rd !== t[i].exp_rd || err !== t[i].exp_err || lat != 2) begin
                errors++;
                $display("FAIL extension[%0d] got rd=%h err=%b lat=%0d want rd=%h err=%b lat=2",
                         i, rd, err, lat, t[i].exp_rd, t[i].exp_err);
            end
        end
    endtask

    task automatic test_errors();
        op_t t [9];
        logic [31:0] rd, mrd;
        logic err, merr;
        int lat, ac;
        t[0] = '{2'b01, 2'b10, 1'b0, 32'h12,  32'h0,        32'h0,        1'b1};
        t[1] = '{2'b10, 2'b10, 1'b0, 32'h0,   32'hA5A5A5A5, 32'h0,        1'b0};
        t[2] = '{2'b10, 2'b10, 1'b0, 32'h400, 32'h11111111, 32'h0,        1'b1};
        t[3] = '{2'b01, 2'b10, 1'b0, 32'h0,   32'h0,        32'hA5A5A5A5, 1'b0};
        t[4] = '{2'b11, 2'b10, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1};
        t[5] = '{2'b00, 2'b10, 1'b0, 32'h10,  32'h99999999, 32'h0,        1'b1};
        t[6] = '{2'b10, 2'b01, 1'b0, 32'h11,  32'h77777777, 32'h0,        1'b1};
        t[7] = '{2'b01, 2'b11, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1};
        t[8] = '{2'b01, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEAD55EF, 1'b0};
        for (int i = 0; i < 9; i++) begin
            model_access(t[i].acc, t[i].sz, t[i].sus, t[i].a, t[i].wd, mrd, merr);
            do_req(0, t[i].acc, t[i].sz, t[i].sus, t[i].a, t[i].wd, 1'b0, rd, err, lat, ac);
            checks++;
            if (rd !== t[i].exp_rd || err !== t[i].exp_err || lat != 2) begin
                errors++;
                $display("FAIL errors[%0d] got rd=%h err=%b lat=%0d want rd=%h err=%b lat=2",
                         i, rd, err, lat, t[i].exp_rd, t[i].exp_err);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int n;
        bit bad;
        acc_type = 2'b01; access_sz = 2'b10; s_us = 1'b0; addr = 32'h10; wdata = 32'h0;
        req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (!rsp_valid[0] && n < 12) begin addr = $urandom; @(negedge clk); n++; end
        held = rdata0;
        checks++;
        if (rsp_valid[0] !== 1'b1 || held !== 32'hDEAD55EF || n != 2) begin
            errors++;
            $display("FAIL bp_first got vld=%b rd=%h lat=%0d want vld=1 rd=deadbeef-patched dead55ef lat=2",
                     rsp_valid[0], held, n);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            addr = $urandom;
            @(negedge clk);
            if (rsp_valid[0] !== 1'b1 || rdata0 !== held || req_ready[0] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold got vld=%b rd=%h rdy=%b want vld=1 rd=%h rdy=0",
                     rsp_valid[0], rdata0, req_ready[0], held);
        end
        addr = 32'h10;
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_handshake got vld=%b rdy=%b want vld=0 rdy=1", rsp_valid[0], req_ready[0]);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        checks++;
        if (req_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept got rdy=%b want 0", req_ready[0]);
        end
        n = 0;
        while (!rsp_valid[0] && n < 12) begin @(negedge clk); n++; end
        checks++;
        if (rsp_valid[0] !== 1'b1 || rdata0 !== 32'hDEAD55EF || rsp_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_rsp got vld=%b rd=%h err=%b want vld=1 rd=dead55ef err=0",
                     rsp_valid[0], rdata0, rsp_err[0]);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, mrd;
        logic err, merr;
        int lat, ac, prev;
        logic [31:0] a;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            a = 32'h10 + 32'(4 * (i % 2));
            model_access(2'b01, 2'b10, 1'b0, a, 32'h0, mrd, merr);
            do_req(0, 2'b01, 2'b10, 1'b0, a, 32'h0, 1'b1, rd, err, lat, ac);
            checks++;
            if (rd !== mrd || err !== merr || lat != 2 || (i > 0 && ac - prev != 4)) begin
                errors++;
                $display("FAIL back_to_back[%0d] got rd=%h err=%b lat=%0d gap=%0d want rd=%h err=%b lat=2 gap=4",
                         i, rd, err, lat, ac - prev, mrd, merr);
            end
            prev = ac;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, mrd;
        logic err, merr;
        int lat, ac, n;
        bit bad;
        model_access(2'b10, 2'b10, 1'b0, 32'h20, 32'h0, mrd, merr);
        do_req(0, 2'b10, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, rd, err, lat, ac);
        // write abandoned by a reset during WAIT
        acc_type = 2'b10; access_sz = 2'b10; s_us = 1'b0; addr = 32'h20; wdata = 32'h12345678;
        req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait got vld=%b rdy=%b want vld=0 rdy=0", rsp_valid[0], req_ready[0]);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_wait_release got rdy=%b want 1", req_ready[0]);
        end
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_wait_no_rsp got vld=1 want 0");
        end
        model_access(2'b01, 2'b10, 1'b0, 32'h20, 32'h0, mrd, merr);
        do_req(0, 2'b01, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, rd, err, lat, ac);
        checks++;
        if (rd !== 32'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait_readback got rd=%h err=%b want rd=00000000 err=0", rd, err);
        end
        // write already committed when reset hits RESP
        acc_type = 2'b10; access_sz = 2'b10; s_us = 1'b0; addr = 32'h24; wdata = 32'hCAFEF00D;
        req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        n = 0;
        while (!rsp_valid[0] && n < 12) begin @(negedge clk); n++; end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (rsp_valid[0] !== 1'b0 || n != 2) begin
            errors++;
            $display("FAIL reset_resp got vld=%b lat=%0d want vld=0 lat=2", rsp_valid[0], n);
        end
        @(posedge clk);
        @(negedge clk);
        model_access(2'b10, 2'b10, 1'b0, 32'h24, 32'hCAFEF00D, mrd, merr);
        model_access(2'b01, 2'b10, 1'b0, 32'h24, 32'h0, mrd, merr);
        do_req(0, 2'b01, 2'b10, 1'b0, 32'h24, 32'h0, 1'b0, rd, err, lat, ac);
        checks++;
        if (rd !== 32'hCAFEF00D || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp_readback got rd=%h err=%b want rd=cafef00d err=0", rd, err);
        end
    endtask

    task automatic test_latency_sweep();
        logic [31:0] rd;
        logic err;
        int lat, ac;
        for (int k = 1; k < 3; k++) begin
            do_req(k, 2'b10, 2'b10, 1'b0, 32'h8, 32'h0BADF00D, 1'b0, rd, err, lat, ac);
            checks++;
            if (lat != (k == 1 ? 1 : 4) || err !== 1'b0 || rd !== 32'h0) begin
                errors++;
                $display("FAIL sweep_write inst=%0d got lat=%0d err=%b rd=%h want lat=%0d err=0 rd=0",
                         k, lat, err, rd, (k == 1 ? 1 : 4));
            end
            do_req(k, 2'b01, 2'b01, 1'b0, 32'hA, 32'h0, 1'b0, rd, err, lat, ac);
            checks++;
            if (lat != (k == 1 ? 1 : 4) || err !== 1'b0 || rd !== 32'h00000BAD) begin
                errors++;
                $display("FAIL sweep_read inst=%0d got lat=%0d err=%b rd=%h want lat=%0d err=0 rd=00000bad",
                         k, lat, err, rd, (k == 1 ? 1 : 4));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, a, wd;
        logic [1:0] acc, sz;
        logic sus, err, merr;
        int lat, ac, r;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            model_access(2'b10, 2'b10, 1'b0, 32'(4 * i), wd, mrd, merr);
            do_req(0, 2'b10, 2'b10, 1'b0, 32'(4 * i), wd, 1'b0, rd, err, lat, ac);
        end
        for (int i = 0; i < 60; i++) begin
            r   = int'($urandom_range(0, 9));
            acc = (r == 0) ? 2'(3 * $urandom_range(0, 1)) : ((r < 5) ? 2'b01 : 2'b10);
            sz  = ($urandom_range(0, 14) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            sus = 1'($urandom);
            wd  = $urandom;
            a   = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h400) : 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b10) a[1:0] = 2'b00;
                if (sz == 2'b01) a[0]   = 1'b0;
            end
            model_access(acc, sz, sus, a, wd, mrd, merr);
            do_req(0, acc, sz, sus, a, wd, 1'($urandom), rd, err, lat, ac);
            checks++;
            if (rd !== mrd || err !== merr || lat != 2) begin
                errors++;
                $display("FAIL random[%0d] acc=%b sz=%b sus=%b a=%h wd=%h got rd=%h err=%b lat=%0d want rd=%h err=%b lat=2",
                         i, acc, sz, sus, a, wd, rd, err, lat, mrd, merr);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; req_valid = 3'b000; rsp_ready = 3'b000;
        acc_type = 2'b00; access_sz = 2'b00; s_us = 1'b0; addr = 32'h0; wdata = 32'h0;
        test_reset();
        test_word_roundtrip();
        test_extension();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_latency_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 2: cycles from request accept to rsp_valid assertion; legal range 1..4.
REQ-002 Parameter DEPTH_WORDS, default 256: 32-bit words of storage, giving a 1 KB byte space at addr[9:0].
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-005 req_valid  input  1  pipeline MEM stage presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 acc_type  input  2  01 = read, 10 = write; 00 and 11 are illegal.
REQ-008 access_sz  input  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-009 s_us  input  1  load extension: 0 = signed, 1 = unsigned.
REQ-010 addr  input  32  little-endian byte address.
REQ-011 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 rsp_valid  output  1  response is valid.
REQ-013 rsp_ready  input  1  pipeline accepts the response.
REQ-014 rsp_rdata  output  32  extended load data; 0 for writes and errors.
REQ-015 rsp_err  output  1  request was illegal, misaligned or out of range.

Function
REQ-016 FSM states: IDLE, WAIT, RESP. req_ready SHALL be 1 only in IDLE.
REQ-017 IDLE transitions to WAIT on req_valid && req_ready. At that edge, acc_type, access_sz, s_us, addr and wdata SHALL be captured in internal registers; later input changes have no effect.
REQ-018 WAIT behaviour:
- A down-counter SHALL load LATENCY-1 on accept.
- WAIT -> RESP when the counter is 0.
- rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-019 RESP behaviour:
- rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_valid && rsp_ready.
- On that handshake the FSM returns to IDLE.
REQ-020 rsp_ready asserted early, before or during WAIT, SHALL have no effect.
REQ-021 Error condition, any of:
- acc_type is 00 or 11;
- access_sz is 11;
- half access with addr[0] = 1;
- word access with addr[1:0] != 00;
- addr[31:10] != 0.
REQ-022 On error: no memory change, rsp_rdata = 0, rsp_err = 1, same latency as a normal access.
REQ-023 Write commit SHALL occur on the WAIT -> RESP edge, using byte enables:
- byte: lane addr[1:0] only, taking wdata[7:0];
- half: lanes addr[1] * 2 and +1, taking wdata[15:0];
- word: all lanes.
REQ-024 Read data SHALL be sampled on the WAIT -> RESP edge and extended as follows:
- byte/half: selected lane(s), sign-extended if s_us = 0, zero-extended if s_us = 1;
- word: passed through unmodified; s_us is ignored.
REQ-025 A read following a write to the same address SHALL return the written data, with no stale data.
REQ-026 Lanes not enabled by a write SHALL retain their previous value.
REQ-027 The responder holds one outstanding request at most; there is no queueing.
REQ-028 Throughput SHALL be at most one request per LATENCY+2 cycles when rsp_ready is held high. A new request may be accepted on the cycle after the response handshake.

Reset
REQ-029 reset = 0 at a clk edge SHALL force the following, overriding every other input that cycle:
- state IDLE, counter 0;
- req_ready = 0 during the reset cycle, 1 from the first edge with reset = 1;
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-030 Memory contents SHALL NOT be cleared by reset.
REQ-031 Reset in WAIT SHALL abandon the request: a pending write is not committed and no response is issued.
REQ-032 Reset in RESP SHALL drop the response. A write already committed on entry to RESP remains in memory.

Verification
REQ-033 Word round trip, LATENCY = 2:
- stimulus: write 0xDEADBEEF to addr 0x10; then read word from 0x10;
- response: read rsp_rdata = 0xDEADBEEF, rsp_err = 0; rsp_valid rises 2 cycles after each accept.
REQ-034 Byte and half extension, with 0x10 = 0xDEADBEEF:
- read byte 0x13, s_us = 0 -> 0xFFFFFFDE;
- read byte 0x13, s_us = 1 -> 0x000000DE;
- read half 0x10, s_us = 0 -> 0xFFFFBEEF;
- write byte 0x11 = 0x55, then read word 0x10 -> 0xDEAD55EF.
REQ-035 Errors:
- word read at 0x12 -> rsp_err = 1, rdata = 0;
- write at 0x400 -> rsp_err = 1, memory unchanged;
- acc_type = 11 -> rsp_err = 1.
REQ-036 Backpressure:
- stimulus: hold rsp_ready = 0 for 5 cycles after rsp_valid rises, while driving req_valid = 1 with changing addr;
- response: rsp_valid and rsp_rdata stable throughout, req_ready = 0, no second accept until the cycle after the handshake.
REQ-037 Reset mid-write:
- stimulus: word write 0x12345678 to 0x20 (prior value 0), reset = 0 during WAIT;
- response: no rsp_valid; a subsequent read of 0x20 returns 0x00000000; req_ready = 1 on the first edge after reset releases.
REQ-038 Parameter sweep: run LATENCY = 1 and 4; the cycle from accept to rsp_valid equals LATENCY in both.
